icache_mem_ctrl: RTL and testbench
==================================

# icache_mem_ctrl

Sequencer and arbiter for the two-way instruction-cache tag and data SRAMs. It shares the single tag enable and data enable between three clients:
- a post-reset/flush invalidate sweep,
- the miss-handler refill writer,
- the fetch-stage lookup reader.

It sits between the fetch pipeline and the memory block, and drives every SRAM control, address and write-data pin. Tag arrays A/B and data arrays A/B are way A and way B. A line is two half-beats, addressed {index, half}.

## Interface
Parameters (widths come from the package):
- INIT_ON_RST, 1, 1 = run the invalidate sweep after reset; 0 = go straight to IDLE (simulation speed-up only).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-high reset; the port name follows codebase convention
- flush_req  in  1  single-cycle pulse; invalidate all tags
- init_busy  out  1  sweep in progress
- lookup_req_vld  in  1  lookup request
- lookup_req_rdy  out  1  lookup accepted when vld & rdy
- lookup_index  in  ICACHE_INDEX_WIDTH  set index
- lookup_half  in  1  half-line select
- lookup_rsp_vld  out  1  response valid
- lookup_tagA / lookup_tagB  out  ICACHE_TAG_RAM_WIDTH  tag words, bit MSB = valid
- lookup_dataA / lookup_dataB  out  ICACHE_DATA_WIDTH/2  half-line data per way
- refill_req_vld  in  1  refill request
- refill_req_rdy  out  1  refill accepted when vld & rdy
- refill_way  in  1  0 = A, 1 = B
- refill_index  in  ICACHE_INDEX_WIDTH  set index
- refill_tag  in  ICACHE_TAG_RAM_WIDTH-1  tag without valid bit
- refill_data  in  ICACHE_DATA_WIDTH  full line; [low half] = half 0
- refill_done  out  1  one-cycle pulse when the line is fully written
- SRAM side, out: tagram_en, tag_arrayA_wr_en, tag_arrayA_addr, tag_arrayA_din, tag_arrayB_* (same set), dataram_en, A_data_array_wr_en, A_data_array_addr, A_data_array_din, B_data_array_* (same set)
- SRAM side, in: tag_arrayA_dout, tag_arrayB_dout, A_data_array_dout, B_data_array_dout

## Operation
FSM states and transitions:
- INIT: counter sweeps index 0..2^IW−1, one per cycle. Each cycle sets tagram_en=1, both tag wr_en=1, din=0. After the last index: IDLE.
- IDLE:
  - A pending flush has highest priority: counter clears, go to INIT.
  - Otherwise refill: refill_req_rdy=1, and on accept go to REF0.
  - Lookup rdy = (state==IDLE) & !refill_req_vld & !flush_pending.
- REF0:
  - Selected tag array: wr_en=1, din={1'b1, refill_tag}.
  - Selected data array: wr_en=1, addr={index,0}, din=low half.
  - Go to REF1.
- REF1:
  - Selected data array: addr={index,1}, din=high half, wr_en=1.
  - refill_done=1. Go to IDLE.

Refill and lookup rules:
- Refill fields are captured on accept and held stable internally through REF1.
- The unselected way sees no write.

Lookup access:
- On accept: tagram_en=1 and dataram_en=1, no writes. Both tag arrays get addr=lookup_index. Both data arrays get addr={lookup_index, lookup_half}.
- lookup_rsp_vld asserts the next cycle.
- lookup_tagA/B and lookup_dataA/B are combinational pass-through of the SRAM douts. They are meaningful only while lookup_rsp_vld=1.

Flush:
- flush_req seen in any state other than INIT sets flush_pending.
- flush_pending is cleared on entry to INIT.
- flush_req during INIT is ignored, because the sweep already covers it.

Reset:
- Reset mid-sweep or mid-refill aborts the operation.
- The state goes to INIT (or IDLE if INIT_ON_RST=0), and any partial refill is discarded.

## Timing
Reset values of outputs:
- All enables, wr_en and rdy outputs are 0.
- lookup_rsp_vld=0, refill_done=0.
- Addresses and din are 0.
- init_busy=1 (0 if INIT_ON_RST=0).

Latency:
- Lookup: accept at cycle N, lookup_rsp_vld at N+1. Throughput is one lookup per cycle while in IDLE with no refill.
- Refill: accept at N; REF0 write at N+1; REF1 write plus refill_done at N+2. refill_req_rdy=0 in REF0 and REF1.
- Sweep: exactly 2^IW cycles with init_busy=1. The first IDLE cycle follows.

Arbitration and ordering:
- Simultaneous lookup and refill: refill wins and lookup stalls, since rdy=0. A lookup issued the cycle after REF1 sees the new line.
- The SRAM control outputs are combinational from the state and the accepted request. No SRAM port is ever driven by two sources in the same cycle.

## Structure
- Shared package: ICACHE_INDEX_WIDTH, ICACHE_TAG_RAM_WIDTH and ICACHE_DATA_WIDTH are already present. Add the typedef icache_ctrl_state_e {INIT, IDLE, REF0, REF1}.
- No sub-module. The sweep counter and refill capture registers are inline. The SRAMs are instantiated by the parent and connected port-to-port.

## Test plan
Benches use ICACHE_INDEX_WIDTH=6.
- Reset release → init_busy high for 64 cycles with tag wr_en on both arrays, then low; a lookup of index 5 returns tagA/tagB MSB=0.
- Refill way B, index 12, tag 0x3A, data {H1,H0} → B data writes at addr 24 and 25, tag_arrayB_din={1,0x3A}, refill_done at accept+2, no way-A writes.
- Lookup index 12, half 1 immediately after the above refill_done → rsp_vld the next cycle, dataB=H1, tagB valid with tag 0x3A.
- Lookup and refill valid in the same cycle → refill accepted; lookup_req_rdy=0 for 3 cycles; lookup accepted in the first IDLE cycle.
- flush_req during REF0 → REF1 completes and refill_done pulses; INIT then runs 64 cycles; the lookup from the previous scenario now returns tag valid=0.
- Assert reset during REF0 → no REF1 write, no refill_done, sweep restarts from index 0.

Source files
------------

// File: rtl/icache_mem_ctrl_pkg.sv
// icache_mem_ctrl_pkg: shared widths and the state type
// for the instruction-cache SRAM sequencer.
package icache_mem_ctrl_pkg;

   localparam int ICACHE_INDEX_WIDTH   = 6;
   localparam int ICACHE_TAG_RAM_WIDTH = 21;
   localparam int ICACHE_DATA_WIDTH    = 64;

   localparam int ICACHE_HALF_WIDTH  = ICACHE_DATA_WIDTH / 2;
   localparam int ICACHE_DADDR_WIDTH = ICACHE_INDEX_WIDTH + 1;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      REF0 = 2'd2,
      REF1 = 2'd3
   } icache_ctrl_state_e;

endpackage

// File: rtl/icache_mem_ctrl.sv
// icache_mem_ctrl: arbitrates the tag/data SRAM enables between
// the invalidate sweep, the refill writer and the lookup reader.
module icache_mem_ctrl
   import icache_mem_ctrl_pkg::*;
#(
   parameter bit INIT_ON_RST = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush_req,
   output logic                              init_busy,
   input  logic                              lookup_req_vld,
   output logic                              lookup_req_rdy,
   input  logic [ICACHE_INDEX_WIDTH-1:0]     lookup_index,
   input  logic                              lookup_half,
   output logic                              lookup_rsp_vld,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0]   lookup_tagA,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0]   lookup_tagB,
   output logic [ICACHE_HALF_WIDTH-1:0]      lookup_dataA,
   output logic [ICACHE_HALF_WIDTH-1:0]      lookup_dataB,
   input  logic                              refill_req_vld,
   output logic                              refill_req_rdy,
   input  logic                              refill_way,
   input  logic [ICACHE_INDEX_WIDTH-1:0]     refill_index,
   input  logic [ICACHE_TAG_RAM_WIDTH-2:0]   refill_tag,
   input  logic [ICACHE_DATA_WIDTH-1:0]      refill_data,
   output logic                              refill_done,
   output logic                              tagram_en,
   output logic                              tag_arrayA_wr_en,
   output logic [ICACHE_INDEX_WIDTH-1:0]     tag_arrayA_addr,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0]   tag_arrayA_din,
   output logic                              tag_arrayB_wr_en,
   output logic [ICACHE_INDEX_WIDTH-1:0]     tag_arrayB_addr,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0]   tag_arrayB_din,
   output logic                              dataram_en,
   output logic                              A_data_array_wr_en,
   output logic [ICACHE_DADDR_WIDTH-1:0]     A_data_array_addr,
   output logic [ICACHE_HALF_WIDTH-1:0]      A_data_array_din,
   output logic                              B_data_array_wr_en,
   output logic [ICACHE_DADDR_WIDTH-1:0]     B_data_array_addr,
   output logic [ICACHE_HALF_WIDTH-1:0]      B_data_array_din,
   input  logic [ICACHE_TAG_RAM_WIDTH-1:0]   tag_arrayA_dout,
   input  logic [ICACHE_TAG_RAM_WIDTH-1:0]   tag_arrayB_dout,
   input  logic [ICACHE_HALF_WIDTH-1:0]      A_data_array_dout,
   input  logic [ICACHE_HALF_WIDTH-1:0]      B_data_array_dout
);

   localparam int IW = ICACHE_INDEX_WIDTH;
   localparam int TW = ICACHE_TAG_RAM_WIDTH;
   localparam int DW = ICACHE_DATA_WIDTH;
   localparam int HW = ICACHE_HALF_WIDTH;

   icache_ctrl_state_e r_state;
   icache_ctrl_state_e w_state_nxt;

   logic [IW-1:0] r_cnt;
   logic          r_flush_pend;
   logic          r_rsp_vld;
   logic          r_ref_way;
   logic [IW-1:0] r_ref_index;
   logic [TW-2:0] r_ref_tag;
   logic [DW-1:0] r_ref_data;

   logic w_active;
   logic w_idle;
   logic w_ref_rdy;
   logic w_lk_rdy;
   logic w_ref_acc;
   logic w_lk_acc;
   logic w_cnt_last;
   logic w_enter_init;

   // rst_n is active-high; all SRAM strobes are held off while it is high
   assign w_active  = ~rst_n;
   assign w_idle    = w_active & (r_state == IDLE);
   assign w_ref_rdy = w_idle & ~r_flush_pend;
   assign w_lk_rdy  = w_ref_rdy & ~refill_req_vld;
   assign w_ref_acc = refill_req_vld & w_ref_rdy;
   assign w_lk_acc  = lookup_req_vld & w_lk_rdy;
   assign w_cnt_last = &r_cnt;
   assign w_enter_init = (w_state_nxt == INIT) & (r_state != INIT);

   assign lookup_req_rdy = w_lk_rdy;
   assign refill_req_rdy = w_ref_rdy;
   assign lookup_rsp_vld = r_rsp_vld;
   assign refill_done    = w_active & (r_state == REF1);
   assign init_busy      = rst_n ? INIT_ON_RST : (r_state == INIT);

   assign lookup_tagA  = tag_arrayA_dout;
   assign lookup_tagB  = tag_arrayB_dout;
   assign lookup_dataA = A_data_array_dout;
   assign lookup_dataB = B_data_array_dout;

   // next-state: a pending flush outranks a refill in IDLE
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         INIT: if (w_cnt_last) w_state_nxt = IDLE;
         IDLE: begin
            if (r_flush_pend)   w_state_nxt = INIT;
            else if (w_ref_acc) w_state_nxt = REF0;
         end
         REF0: w_state_nxt = REF1;
         REF1: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // state, sweep counter, flush latch and lookup response flag
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state      <= INIT_ON_RST ? INIT : IDLE;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_rsp_vld    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= (r_state == INIT) ? r_cnt + 1'b1 : '0;
         r_rsp_vld <= w_lk_acc;
         if (w_enter_init)
            r_flush_pend <= 1'b0;
         else if (flush_req && (r_state != INIT))
            r_flush_pend <= 1'b1;
      end
   end

   // refill fields are frozen at accept so the requester may move on
   always_ff @(posedge clk) begin
      if (w_ref_acc) begin
         r_ref_way   <= refill_way;
         r_ref_index <= refill_index;
         r_ref_tag   <= refill_tag;
         r_ref_data  <= refill_data;
      end
   end

   // SRAM pin drive: exactly one client owns the ports per state
   always_comb begin
      tagram_en          = 1'b0;
      tag_arrayA_wr_en   = 1'b0;
      tag_arrayA_addr    = '0;
      tag_arrayA_din     = '0;
      tag_arrayB_wr_en   = 1'b0;
      tag_arrayB_addr    = '0;
      tag_arrayB_din     = '0;
      dataram_en         = 1'b0;
      A_data_array_wr_en = 1'b0;
      A_data_array_addr  = '0;
      A_data_array_din   = '0;
      B_data_array_wr_en = 1'b0;
      B_data_array_addr  = '0;
      B_data_array_din   = '0;
      if (w_active) begin
         unique case (r_state)
            INIT: begin
               tagram_en        = 1'b1;
               tag_arrayA_wr_en = 1'b1;
               tag_arrayB_wr_en = 1'b1;
               tag_arrayA_addr  = r_cnt;
               tag_arrayB_addr  = r_cnt;
            end
            IDLE: begin
               if (w_lk_acc) begin
                  tagram_en         = 1'b1;
                  dataram_en        = 1'b1;
                  tag_arrayA_addr   = lookup_index;
                  tag_arrayB_addr   = lookup_index;
                  A_data_array_addr = {lookup_index, lookup_half};
                  B_data_array_addr = {lookup_index, lookup_half};
               end
            end
            REF0: begin
               tagram_en         = 1'b1;
               dataram_en        = 1'b1;
               tag_arrayA_addr   = r_ref_index;
               tag_arrayB_addr   = r_ref_index;
               A_data_array_addr = {r_ref_index, 1'b0};
               B_data_array_addr = {r_ref_index, 1'b0};
               if (r_ref_way) begin
                  tag_arrayB_wr_en   = 1'b1;
                  tag_arrayB_din     = {1'b1, r_ref_tag};
                  B_data_array_wr_en = 1'b1;
                  B_data_array_din   = r_ref_data[HW-1:0];
               end else begin
                  tag_arrayA_wr_en   = 1'b1;
                  tag_arrayA_din     = {1'b1, r_ref_tag};
                  A_data_array_wr_en = 1'b1;
                  A_data_array_din   = r_ref_data[HW-1:0];
               end
            end
            REF1: begin
               dataram_en        = 1'b1;
               A_data_array_addr = {r_ref_index, 1'b1};
               B_data_array_addr = {r_ref_index, 1'b1};
               if (r_ref_way) begin
                  B_data_array_wr_en = 1'b1;
                  B_data_array_din   = r_ref_data[DW-1:HW];
               end else begin
                  A_data_array_wr_en = 1'b1;
                  A_data_array_din   = r_ref_data[DW-1:HW];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// tb_icache_mem_ctrl: directed bench with a behavioural two-way
// SRAM model, a lookup vector table and hand-written corner sequences.
module tb_icache_mem_ctrl;
   import icache_mem_ctrl_pkg::*;

   localparam int IW = ICACHE_INDEX_WIDTH;
   localparam int TW = ICACHE_TAG_RAM_WIDTH;
   localparam int DW = ICACHE_DATA_WIDTH;
   localparam int HW = ICACHE_HALF_WIDTH;
   localparam int AW = ICACHE_DADDR_WIDTH;

   logic clk = 1'b0;
   logic rst_n, flush_req, init_busy;
   logic lookup_req_vld, lookup_req_rdy, lookup_half, lookup_rsp_vld;
   logic [IW-1:0] lookup_index;
   logic [TW-1:0] lookup_tagA, lookup_tagB;
   logic [HW-1:0] lookup_dataA, lookup_dataB;
   logic refill_req_vld, refill_req_rdy, refill_way, refill_done;
   logic [IW-1:0] refill_index;
   logic [TW-2:0] refill_tag;
   logic [DW-1:0] refill_data;
   logic tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en;
   logic [IW-1:0] tag_arrayA_addr, tag_arrayB_addr;
   logic [TW-1:0] tag_arrayA_din, tag_arrayB_din;
   logic [TW-1:0] tag_arrayA_dout, tag_arrayB_dout;
   logic dataram_en, A_data_array_wr_en, B_data_array_wr_en;
   logic [AW-1:0] A_data_array_addr, B_data_array_addr;
   logic [HW-1:0] A_data_array_din, B_data_array_din;
   logic [HW-1:0] A_data_array_dout, B_data_array_dout;

   logic          tb_preset;
   logic [TW-1:0] tA_mem [0:(1<<IW)-1];
   logic [TW-1:0] tB_mem [0:(1<<IW)-1];
   logic [HW-1:0] dA_mem [0:(1<<AW)-1];
   logic [HW-1:0] dB_mem [0:(1<<AW)-1];

   int n_chk = 0;
   int n_pass = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   icache_mem_ctrl #(.INIT_ON_RST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
      .init_busy(init_busy),
      .lookup_req_vld(lookup_req_vld), .lookup_req_rdy(lookup_req_rdy),
      .lookup_index(lookup_index), .lookup_half(lookup_half),
      .lookup_rsp_vld(lookup_rsp_vld),
      .lookup_tagA(lookup_tagA), .lookup_tagB(lookup_tagB),
      .lookup_dataA(lookup_dataA), .lookup_dataB(lookup_dataB),
      .refill_req_vld(refill_req_vld), .refill_req_rdy(refill_req_rdy),
      .refill_way(refill_way), .refill_index(refill_index),
      .refill_tag(refill_tag), .refill_data(refill_data),
      .refill_done(refill_done),
      .tagram_en(tagram_en),
      .tag_arrayA_wr_en(tag_arrayA_wr_en),
      .tag_arrayA_addr(tag_arrayA_addr),
      .tag_arrayA_din(tag_arrayA_din),
      .tag_arrayB_wr_en(tag_arrayB_wr_en),
      .tag_arrayB_addr(tag_arrayB_addr),
      .tag_arrayB_din(tag_arrayB_din),
      .dataram_en(dataram_en),
      .A_data_array_wr_en(A_data_array_wr_en),
      .A_data_array_addr(A_data_array_addr),
      .A_data_array_din(A_data_array_din),
      .B_data_array_wr_en(B_data_array_wr_en),
      .B_data_array_addr(B_data_array_addr),
      .B_data_array_din(B_data_array_din),
      .tag_arrayA_dout(tag_arrayA_dout),
      .tag_arrayB_dout(tag_arrayB_dout),
      .A_data_array_dout(A_data_array_dout),
      .B_data_array_dout(B_data_array_dout)
   );

   // single-port synchronous SRAMs, one-cycle read latency
   always @(posedge clk) begin
      if (tb_preset) begin
         for (int i = 0; i < (1 << IW); i++) begin
            tA_mem[i] <= '1;
            tB_mem[i] <= '1;
         end
         for (int i = 0; i < (1 << AW); i++) begin
            dA_mem[i] <= '0;
            dB_mem[i] <= '0;
         end
      end else begin
         if (tagram_en) begin
            if (tag_arrayA_wr_en) tA_mem[tag_arrayA_addr] <= tag_arrayA_din;
            else tag_arrayA_dout <= tA_mem[tag_arrayA_addr];
            if (tag_arrayB_wr_en) tB_mem[tag_arrayB_addr] <= tag_arrayB_din;
            else tag_arrayB_dout <= tB_mem[tag_arrayB_addr];
         end
         if (dataram_en) begin
            if (A_data_array_wr_en) dA_mem[A_data_array_addr] <= A_data_array_din;
            else A_data_array_dout <= dA_mem[A_data_array_addr];
            if (B_data_array_wr_en) dB_mem[B_data_array_addr] <= B_data_array_din;
            else B_data_array_dout <= dB_mem[B_data_array_addr];
         end
      end
   end

   // refill_done pulse counter
   always @(negedge clk) begin
      if (refill_done === 1'b1) n_done++;
   end

   // hard stop in case a sequence wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic count_sweep(input bit flush_mid, output int busy,
                              output int bad);
      busy = 0;
      bad  = 0;
      @(negedge clk);
      while (init_busy && busy < 200) begin
         if (!(tagram_en && tag_arrayA_wr_en && tag_arrayB_wr_en &&
               tag_arrayA_addr == busy[IW-1:0] &&
               tag_arrayB_addr == busy[IW-1:0] &&
               tag_arrayA_din == '0 && tag_arrayB_din == '0 &&
               !dataram_en))
            bad++;
         busy++;
         @(posedge clk); #1;
         flush_req = flush_mid && (busy == 10);
         @(negedge clk);
      end
      flush_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_lookup(input logic [IW-1:0] idx, input logic half,
                            output bit ok, output int wt,
                            output logic [TW-1:0] tA, output logic [TW-1:0] tB,
                            output logic [HW-1:0] dA, output logic [HW-1:0] dB);
      lookup_req_vld = 1'b1;
      lookup_index   = idx;
      lookup_half    = half;
      wt = 0;
      @(negedge clk);
      while (!lookup_req_rdy && wt < 20) begin
         @(posedge clk); #1;
         wt++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      lookup_req_vld = 1'b0;
      @(negedge clk);
      ok = (wt < 20) && lookup_rsp_vld;
      tA = lookup_tagA;
      tB = lookup_tagB;
      dA = lookup_dataA;
      dB = lookup_dataB;
      @(posedge clk); #1;
   endtask

   task automatic do_refill(input logic way, input logic [IW-1:0] idx,
                            input logic [TW-2:0] tag, input logic [DW-1:0] data,
                            output bit ok);
      int n;
      refill_req_vld = 1'b1;
      refill_way     = way;
      refill_index   = idx;
      refill_tag     = tag;
      refill_data    = data;
      n = 0;
      @(negedge clk);
      while (!refill_req_rdy && n < 20) begin
         @(posedge clk); #1;
         n++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      refill_req_vld = 1'b0;
      @(negedge clk);
      ok = (n < 20) && !refill_done;
      @(posedge clk); #1;
      @(negedge clk);
      ok = ok && refill_done;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [IW-1:0] idx;
      logic          half;
      logic [TW-1:0] tA;
      logic [TW-1:0] tB;
      logic [HW-1:0] dA;
      logic [HW-1:0] dB;
   } lk_vec_t;

   lk_vec_t vecs [7];

   initial begin
      bit ok;
      int wt, busy, bad, stall, seen, done0;
      logic [TW-1:0] tA, tB;
      logic [HW-1:0] dA, dB;

      vecs[0] = '{6'd12, 1'b0, {1'b1, 20'h12345}, {1'b1, 20'h0003A},
                  32'hA00C_0000, 32'hB00C_0000};
      vecs[1] = '{6'd12, 1'b1, {1'b1, 20'h12345}, {1'b1, 20'h0003A},
                  32'hA00C_0001, 32'hB00C_0001};
      vecs[2] = '{6'd0, 1'b0, {1'b1, 20'h00001}, 21'h0,
                  32'hA000_0000, 32'h0};
      vecs[3] = '{6'd0, 1'b1, {1'b1, 20'h00001}, 21'h0,
                  32'hA000_0001, 32'h0};
      vecs[4] = '{6'd63, 1'b1, 21'h0, {1'b1, 20'hFFFFF},
                  32'h0, 32'hB03F_0001};
      vecs[5] = '{6'd63, 1'b0, 21'h0, {1'b1, 20'hFFFFF},
                  32'h0, 32'hB03F_0000};
      vecs[6] = '{6'd5, 1'b1, 21'h0, 21'h0, 32'h0, 32'h0};

      rst_n = 1'b1;
      flush_req = 1'b0;
      lookup_req_vld = 1'b0;
      lookup_index = '0;
      lookup_half = 1'b0;
      refill_req_vld = 1'b0;
      refill_way = 1'b0;
      refill_index = '0;
      refill_tag = '0;
      refill_data = '0;
      tb_preset = 1'b1;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_strobes",
            {tagram_en, dataram_en, tag_arrayA_wr_en, tag_arrayB_wr_en,
             A_data_array_wr_en, B_data_array_wr_en, lookup_req_rdy,
             refill_req_rdy, lookup_rsp_vld, refill_done}, 10'b0);
      check("rst_addr_din",
            {tag_arrayA_addr, tag_arrayB_addr, tag_arrayA_din, tag_arrayB_din,
             A_data_array_addr, B_data_array_addr, A_data_array_din,
             B_data_array_din}, '0);
      check("rst_init_busy", init_busy, 1'b1);
      @(posedge clk); #1;
      tb_preset = 1'b0;
      rst_n = 1'b0;

      // power-up sweep
      count_sweep(1'b0, busy, bad);
      check("sweep_len", busy, 64);
      check("sweep_bad_cycles", bad, 0);
      do_lookup(6'd5, 1'b0, ok, wt, tA, tB, dA, dB);
      check("lk5_rsp", ok, 1'b1);
      check("lk5_valid_bits", {tA[TW-1], tB[TW-1]}, 2'b00);

      // refill way B, index 12
      refill_req_vld = 1'b1;
      refill_way = 1'b1;
      refill_index = 6'd12;
      refill_tag = 20'h3A;
      refill_data = {32'hB00C_0001, 32'hB00C_0000};
      @(negedge clk);
      check("ref_rdy_idle", {refill_req_rdy, lookup_req_rdy}, 2'b10);
      @(posedge clk); #1;
      refill_req_vld = 1'b0;
      refill_way = 1'b0;
      refill_index = '0;
      refill_tag = '0;
      refill_data = '0;
      @(negedge clk);
      check("ref0_b_data", {B_data_array_wr_en, B_data_array_addr, B_data_array_din},
            {1'b1, 7'd24, 32'hB00C_0000});
      check("ref0_b_tag", {tag_arrayB_wr_en, tag_arrayB_addr, tag_arrayB_din},
            {1'b1, 6'd12, 1'b1, 20'h3A});
      check("ref0_no_way_a", {tag_arrayA_wr_en, A_data_array_wr_en}, 2'b00);
      check("ref0_ctl", {refill_done, refill_req_rdy, lookup_req_rdy}, 3'b000);
      @(posedge clk); #1;
      @(negedge clk);
      check("ref1_b_data", {B_data_array_wr_en, B_data_array_addr, B_data_array_din},
            {1'b1, 7'd25, 32'hB00C_0001});
      check("ref1_ctl",
            {refill_done, refill_req_rdy, tag_arrayA_wr_en, tag_arrayB_wr_en,
             A_data_array_wr_en}, 5'b10000);
      @(posedge clk); #1;

      // lookup immediately after the refill
      do_lookup(6'd12, 1'b1, ok, wt, tA, tB, dA, dB);
      check("lk12_rsp", ok, 1'b1);
      check("lk12_no_wait", wt, 0);
      check("lk12_way_b", {tB, dB}, {1'b1, 20'h3A, 32'hB00C_0001});
      check("lk12_way_a_invalid", tA[TW-1], 1'b0);
      check("done_single_pulse", n_done, 1);

      // more lines, then the lookup vector table
      do_refill(1'b0, 6'd12, 20'h12345, {32'hA00C_0001, 32'hA00C_0000}, ok);
      check("refill_a12", ok, 1'b1);
      do_refill(1'b0, 6'd0, 20'h00001, {32'hA000_0001, 32'hA000_0000}, ok);
      check("refill_a0", ok, 1'b1);
      do_refill(1'b1, 6'd63, 20'hFFFFF, {32'hB03F_0001, 32'hB03F_0000}, ok);
      check("refill_b63", ok, 1'b1);
      for (int v = 0; v < 7; v++) begin
         do_lookup(vecs[v].idx, vecs[v].half, ok, wt, tA, tB, dA, dB);
         check($sformatf("vec%0d_rsp", v), ok, 1'b1);
         check($sformatf("vec%0d_data", v), {tA, tB, dA, dB},
               {vecs[v].tA, vecs[v].tB, vecs[v].dA, vecs[v].dB});
      end

      // simultaneous lookup and refill
      refill_req_vld = 1'b1;
      refill_way = 1'b0;
      refill_index = 6'd20;
      refill_tag = 20'h15;
      refill_data = {32'hC014_0001, 32'hC014_0000};
      lookup_req_vld = 1'b1;
      lookup_index = 6'd20;
      lookup_half = 1'b0;
      @(negedge clk);
      check("arb_rdy", {refill_req_rdy, lookup_req_rdy}, 2'b10);
      stall = 0;
      while (!lookup_req_rdy && stall < 10) begin
         stall++;
         @(posedge clk); #1;
         refill_req_vld = 1'b0;
         @(negedge clk);
      end
      check("arb_stall_cycles", stall, 3);
      @(posedge clk); #1;
      lookup_req_vld = 1'b0;
      @(negedge clk);
      check("arb_rsp_new_line", {lookup_rsp_vld, lookup_tagA, lookup_dataA},
            {1'b1, 1'b1, 20'h15, 32'hC014_0000});
      @(posedge clk); #1;

      // flush during REF0
      refill_req_vld = 1'b1;
      refill_way = 1'b1;
      refill_index = 6'd40;
      refill_tag = 20'h7;
      refill_data = {32'hD028_0001, 32'hD028_0000};
      @(negedge clk);
      check("fl_accept", refill_req_rdy, 1'b1);
      @(posedge clk); #1;
      refill_req_vld = 1'b0;
      flush_req = 1'b1;
      @(negedge clk);
      check("fl_ref0_write", B_data_array_wr_en, 1'b1);
      @(posedge clk); #1;
      flush_req = 1'b0;
      @(negedge clk);
      check("fl_ref1_done", {refill_done, init_busy}, 2'b10);
      @(posedge clk); #1;
      lookup_req_vld = 1'b1;
      lookup_index = 6'd12;
      @(negedge clk);
      check("fl_pending_blocks",
            {lookup_req_rdy, refill_req_rdy, init_busy, tagram_en}, 4'b0);
      @(posedge clk); #1;
      lookup_req_vld = 1'b0;
      count_sweep(1'b1, busy, bad);
      check("fl_sweep_len", busy, 64);
      check("fl_sweep_bad_cycles", bad, 0);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (init_busy) seen++;
         @(posedge clk); #1;
      end
      check("fl_in_init_ignored", seen, 0);
      do_lookup(6'd12, 1'b1, ok, wt, tA, tB, dA, dB);
      check("fl_lk12", {ok, tA[TW-1], tB[TW-1]}, 3'b100);
      do_lookup(6'd40, 1'b0, ok, wt, tA, tB, dA, dB);
      check("fl_lk40", {ok, tB[TW-1]}, 2'b10);

      // reset during REF0
      done0 = n_done;
      refill_req_vld = 1'b1;
      refill_way = 1'b0;
      refill_index = 6'd33;
      refill_tag = 20'h11;
      refill_data = {32'hE021_0001, 32'hE021_0000};
      @(negedge clk);
      check("rr_accept", refill_req_rdy, 1'b1);
      @(posedge clk); #1;
      refill_req_vld = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rr_ref0_gated",
            {tagram_en, dataram_en, tag_arrayA_wr_en, A_data_array_wr_en,
             refill_done, init_busy}, 6'b000001);
      @(posedge clk); #1;
      rst_n = 1'b0;
      count_sweep(1'b0, busy, bad);
      check("rr_sweep_len", busy, 64);
      check("rr_sweep_from_0", bad, 0);
      check("rr_no_done", n_done, done0);
      check("rr_no_data_write", {dA_mem[66], dA_mem[67]}, 64'h0);
      do_lookup(6'd33, 1'b0, ok, wt, tA, tB, dA, dB);
      check("rr_lk33", {ok, tA[TW-1]}, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
